// File: rtl/axi4_lite_layer_output.sv
// Final-layer result block: captures NUM_OUT activations, signed argmax, AXI4-Lite regs,
// one-shot AXI4-Stream dump. Optional interrupt behind AXIL_OUT_IRQ_EN.
`timescale 1ns/1ps
module axi4_lite_layer_output #(
  parameter int NUM_OUT = 10,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [ADDR_W-1:0]           s_axil_awaddr,
  input  logic [2:0]                  s_axil_awprot,
  input  logic                        s_axil_awvalid,
  output logic                        s_axil_awready,
  input  logic [31:0]                 s_axil_wdata,
  input  logic [3:0]                  s_axil_wstrb,
  input  logic                        s_axil_wvalid,
  output logic                        s_axil_wready,
  output logic [1:0]                  s_axil_bresp,
  output logic                        s_axil_bvalid,
  input  logic                        s_axil_bready,
  input  logic [ADDR_W-1:0]           s_axil_araddr,
  input  logic [2:0]                  s_axil_arprot,
  input  logic                        s_axil_arvalid,
  output logic                        s_axil_arready,
  output logic [31:0]                 s_axil_rdata,
  output logic [1:0]                  s_axil_rresp,
  output logic                        s_axil_rvalid,
  input  logic                        s_axil_rready,
  input  logic [NUM_OUT*DATA_W-1:0]   in_data,
  input  logic [NUM_OUT-1:0]          in_done,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast
`ifdef AXIL_OUT_IRQ_EN
  ,
  output logic                        irq
`endif
);

  localparam int IW = $clog2(NUM_OUT);
  localparam logic [IW-1:0] LAST = IW'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    S_CAP,
    S_SCAN,
    S_STRM,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_OUT-1:0]  cap_q, cap_d;
  logic [DATA_W-1:0]   val_q [NUM_OUT];
  logic [DATA_W-1:0]   val_d [NUM_OUT];
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       amax_q, amax_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic                sdone_q, sdone_d;

  logic                bvalid_q;
  logic [1:0]          bresp_q;
  logic                rvalid_q;
  logic [1:0]          rresp_q;
  logic [31:0]         rdata_q;
  logic                irq_en;

  function automatic logic [31:0] sx32(input logic [DATA_W-1:0] v);
    logic [DATA_W+31:0] t;
    t = {{32{v[DATA_W-1]}}, v};
    return t[31:0];
  endfunction

  // write channel decode
  logic        wr_hs;
  logic [31:0] wa;
  logic        wr_ok;
  logic        clr;
  logic        w1c;

  assign wa     = 32'(s_axil_awaddr[ADDR_W-1:2]);
  assign wr_hs  = s_axil_awvalid & s_axil_wvalid & ~bvalid_q;
  assign wr_ok  = (wa == 32'd0) | (wa == 32'd1);
  assign clr    = wr_hs & (wa == 32'd0) & s_axil_wstrb[0] & s_axil_wdata[0];
  assign w1c    = wr_hs & (wa == 32'd1) & s_axil_wstrb[0] & s_axil_wdata[2];

  assign s_axil_awready = wr_hs;
  assign s_axil_wready  = wr_hs;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else if (wr_hs) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_ok ? 2'b00 : 2'b10;
    end else if (s_axil_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // capture / scan / stream sequencing
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_CAP;
      cap_q   <= '0;
      idx_q   <= '0;
      amax_q  <= '0;
      max_q   <= '0;
      sdone_q <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) val_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
      amax_q  <= amax_d;
      max_q   <= max_d;
      sdone_q <= sdone_d;
      val_q   <= val_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    val_d   = val_q;
    idx_d   = idx_q;
    amax_d  = amax_q;
    max_d   = max_q;
    sdone_d = sdone_q;
    unique case (state_q)
      S_CAP: begin
        for (int i = 0; i < NUM_OUT; i++) begin
          if (in_done[i] && !cap_q[i]) begin
            cap_d[i] = 1'b1;
            val_d[i] = in_data[i*DATA_W +: DATA_W];
          end
        end
        if (&cap_q) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        // strict '>' keeps the lowest index on ties
        if ((idx_q == '0) ||
            ($signed(val_q[idx_q]) > $signed(max_q))) begin
          max_d  = val_q[idx_q];
          amax_d = idx_q;
        end
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = S_STRM;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_STRM: begin
        if (m_axis_tready) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = S_DONE;
            sdone_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
      end
      default: state_d = S_CAP;
    endcase
    if (w1c) sdone_d = 1'b0;
    if (clr) begin
      state_d = S_CAP;
      cap_d   = '0;
      idx_d   = '0;
      amax_d  = '0;
      max_d   = '0;
      sdone_d = 1'b0;
    end
  end

  assign m_axis_tvalid = (state_q == S_STRM);
  assign m_axis_tlast  = m_axis_tvalid & (idx_q == LAST);
  assign m_axis_tdata  = m_axis_tvalid ? val_q[idx_q] : '0;

`ifdef AXIL_OUT_IRQ_EN
  logic irq_en_q;
  logic irq_q, irq_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_hs && (wa == 32'd0) && s_axil_wstrb[0])
        irq_en_q <= s_axil_wdata[1];
      irq_q <= irq_d;
    end
  end

  always_comb begin
    irq_d = irq_q;
    if ((state_q == S_STRM) && (state_d == S_DONE) && irq_en_q)
      irq_d = 1'b1;
    if (w1c || clr) irq_d = 1'b0;
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
`endif

  // read channel
  logic [31:0] ra;
  logic [31:0] ch;
  logic [7:0]  cnt;
  logic        res_rdy;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        ar_hs;

  assign ra      = 32'(s_axil_araddr[ADDR_W-1:2]);
  assign ch      = ra - 32'd4;
  assign res_rdy = (state_q == S_STRM) | (state_q == S_DONE);
  assign ar_hs   = s_axil_arvalid & ~rvalid_q;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_OUT; i++) cnt = cnt + 8'(cap_q[i]);
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    unique case (1'b1)
      ra == 32'd0: rd_data = {30'd0, irq_en, 1'b0};
      ra == 32'd1: rd_data = {16'd0, cnt, 5'd0, sdone_q, res_rdy, &cap_q};
      ra == 32'd2: rd_data = 32'(amax_q);
      ra == 32'd3: rd_data = sx32(max_q);
      (ra >= 32'd4) && (ch < 32'(NUM_OUT)):
        rd_data = cap_q[ch[IW-1:0]] ? sx32(val_q[ch[IW-1:0]]) : '0;
      default: rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_err ? 2'b10 : 2'b00;
    end else if (s_axil_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axil_arready = ~rvalid_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0],
                       s_axil_araddr[1:0], s_axil_wdata, s_axil_wstrb[3:1]};

endmodule
